seq_frame_tx: RTL and testbench
===============================

// Module: seq_frame_tx
// PURPOSE
//   Bit-serial frame transmitter that drives a single-bit line for the "0110" sequence detector.
//   On a start request it captures a parallel data word, then emits the sync pattern followed by the data word, MSB-first, one bit per clock.
//   Provides busy/done handshake to the controlling logic; the idle line level never advances the detector.
// PARAMETERS
//   DATA_W   8        payload width in bits (>=1)
//   SYNC_W   4        sync pattern width in bits (>=1)
//   SYNC     4'b0110  sync pattern, sent MSB-first (SYNC[SYNC_W-1] first)
// PORTS
//   clock    in   1       system clock, all logic on rising edge
//   reset    in   1       asynchronous, active-low reset (0 = reset)
//   start    in   1       frame request, sampled on rising clock edge
//   data_in  in   DATA_W  payload, captured on the edge that accepts start
//   x        out  1       serial line out (registered)
//   valid    out  1       high while x carries a frame bit (sync/data/parity)
//   busy     out  1       high from accept edge until last frame bit done
//   done     out  1       one-cycle pulse after last frame bit
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, x=1, valid=0, busy=0, done=0,
//     bit counter=0, shift register=0. Release is synchronous to clock.
//   - Moore FSM, all outputs registered; states IDLE, SYNC, DATA, (PAR).
//   - IDLE: x=1 (idle level), valid=0, busy=0. start==1 at an edge ->
//     capture data_in, go SYNC; SYNC[SYNC_W-1] appears on x that same edge
//     (first frame bit visible in the cycle after start is sampled).
//   - SYNC: SYNC_W cycles, bits SYNC[SYNC_W-1]..SYNC[0]; valid=1, busy=1.
//   - DATA: DATA_W cycles, captured word MSB-first; valid=1, busy=1.
//   - After the last DATA (or PAR) bit: -> IDLE; x=1, valid=0, busy=0,
//     done=1 for exactly that one cycle.
//   - Frame length L = SYNC_W + DATA_W (+1 with parity); busy high L cycles.
//   - start while busy==1: ignored, no queuing; data_in not re-captured.
//   - start high in the done cycle (state IDLE): accepted; next frame
//     starts with no idle gap (done and new SYNC MSB sequence back-to-back:
//     done cycle shows x=1, following cycle shows first sync bit).
//   - start held high continuously: frames repeat with one idle cycle
//     (the done cycle) between them.
//   - Reset mid-frame: frame aborted immediately, outputs to reset values,
//     no done pulse; the next frame needs a fresh start after release.
//   - Bit counter sized $clog2(max(SYNC_W,DATA_W)+1); counts down, state
//     changes when it reaches 0. No bit stuffing: payload containing the
//     sync pattern is the user's responsibility.
// CONFIGURATION
//   SEQ_TX_PARITY_EN defined: state PAR follows DATA; one extra bit
//     x = ^data (even parity: total ones in payload+parity is even);
//     valid=1, busy=1 during it; L = SYNC_W + DATA_W + 1.
//   SEQ_TX_PARITY_EN undefined: no PAR state; DATA -> IDLE directly;
//     L = SYNC_W + DATA_W.
// TESTING
//   1 Reset low mid-idle -> x=1, valid=0, busy=0, done=0 immediately
//     (without waiting for a clock edge).
//   2 start=1 one cycle, data_in=8'hA5 -> x over 12 cycles =
//     0,1,1,0,1,0,1,0,0,1,0,1; valid/busy high 12 cycles; done pulse on
//     13th; a connected 0110 detector asserts z on the 4th bit.
//   3 start pulsed again at bit 5 of a frame with data_in=8'h00 -> ignored;
//     frame still sends 8'hA5 payload; single done pulse.
//   4 start held high, data_in=8'h3C -> back-to-back frames, exactly one
//     x=1/valid=0 cycle (with done=1) between them.
//   5 reset asserted at bit 7 of a frame -> x=1, busy=0, no done;
//     after release, start with 8'hFF -> complete, correct frame.
//   6 SEQ_TX_PARITY_EN, data_in=8'h07 -> 13-bit frame, last bit=1;
//     data_in=8'h03 -> last bit=0; busy 13 cycles.

Source files
------------

// File: rtl/seq_frame_tx_if.sv
// ---------------------------------------------------------------------------
// seq_frame_tx_if
// Handshake and serial-line bundle between a controller and the bit-serial
// frame transmitter (seq_frame_tx).
//
// Signals
//   start    controller -> tx   frame request, sampled on rising clock edge
//   data_in  controller -> tx   payload word, captured when start is accepted
//   x        tx -> controller   serial line (idle level 1)
//   valid    tx -> controller   x currently carries a frame bit
//   busy     tx -> controller   a frame is in flight
//   done     tx -> controller   one-cycle pulse after the last frame bit
//
// Modports
//   master   controller side (drives start/data_in)
//   slave    transmitter side (drives x/valid/busy/done)
// ---------------------------------------------------------------------------
interface seq_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] data_in;
   logic              x;
   logic              valid;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output data_in,
      input  x,
      input  valid,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data_in,
      output x,
      output valid,
      output busy,
      output done
   );
endinterface

// File: rtl/seq_frame_tx.sv
// ---------------------------------------------------------------------------
// seq_frame_tx
// Bit-serial frame transmitter feeding the "0110" sequence detector. On an
// accepted start it captures data_in and sends SYNC (MSB-first) followed by
// the payload (MSB-first), one bit per clock. The idle line level is 1, which
// never advances the detector.
//
// Parameters
//   DATA_W   payload width in bits (>=1)
//   SYNC_W   sync pattern width in bits (>=1)
//   SYNC     sync pattern, SYNC[SYNC_W-1] sent first
//
// Ports
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset (0 = reset)
//   bus      seq_frame_tx_if.slave: start, data_in in; x, valid, busy, done out
//
// Configuration
//   SEQ_TX_PARITY_EN  when defined, one even-parity bit (^payload) follows the
//                     payload; otherwise the frame ends after the payload.
// ---------------------------------------------------------------------------
module seq_frame_tx #(
   parameter int                DATA_W = 8,
   parameter int                SYNC_W = 4,
   parameter logic [SYNC_W-1:0] SYNC   = 4'b0110
) (
   input  logic          clock,
   input  logic          reset,
   seq_frame_tx_if.slave bus
);

   localparam int FRAME_W = SYNC_W + DATA_W;
   localparam int MAX_W   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int CNT_W   = $clog2(MAX_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA
`ifdef SEQ_TX_PARITY_EN
      , ST_PAR
`endif
   } state_t;

   state_t               state_q, state_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [FRAME_W-1:0]   shreg_q, shreg_n;
   logic [FRAME_W-1:0]   frame_word;
   logic                 x_q, x_n;
   logic                 valid_q, valid_n;
   logic                 busy_q, busy_n;
   logic                 done_q, done_n;
`ifdef SEQ_TX_PARITY_EN
   logic                 parity_q, parity_n;
`endif

   // The sync pattern and payload share one shift register, so every frame
   // bit after the first is simply the register MSB.
   assign frame_word = {SYNC, bus.data_in};

   // State and registered outputs. Reset parks the line at its idle level and
   // aborts any frame in flight without a done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         x_q      <= 1'b1;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         shreg_q  <= shreg_n;
         x_q      <= x_n;
         valid_q  <= valid_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
`ifdef SEQ_TX_PARITY_EN
         parity_q <= parity_n;
`endif
      end
   end

   // Next-state and next-output logic. The counter holds the number of bits
   // still to come in the current section after the one being loaded onto x,
   // so a section ends when it reads 0. Outputs default to the idle values,
   // which also makes the done cycle fall out of the IDLE default path.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      shreg_n  = shreg_q;
      x_n      = 1'b1;
      valid_n  = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity_n = parity_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_n  = ST_SYNC;
               cnt_n    = CNT_W'(SYNC_W - 1);
               x_n      = frame_word[FRAME_W-1];
               shreg_n  = frame_word << 1;
               valid_n  = 1'b1;
               busy_n   = 1'b1;
`ifdef SEQ_TX_PARITY_EN
               parity_n = ^bus.data_in;
`endif
            end
         end
         ST_SYNC: begin
            x_n     = shreg_q[FRAME_W-1];
            shreg_n = shreg_q << 1;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            if (cnt_q == '0) begin
               state_n = ST_DATA;
               cnt_n   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
               state_n = ST_PAR;
               x_n     = parity_q;
               valid_n = 1'b1;
               busy_n  = 1'b1;
`else
               state_n = ST_IDLE;
               done_n  = 1'b1;
`endif
            end else begin
               x_n     = shreg_q[FRAME_W-1];
               shreg_n = shreg_q << 1;
               cnt_n   = cnt_q - CNT_W'(1);
               valid_n = 1'b1;
               busy_n  = 1'b1;
            end
         end
`ifdef SEQ_TX_PARITY_EN
         ST_PAR: begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
         end
`endif
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign bus.x     = x_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_frame_tx
// Directed bench for seq_frame_tx: a table of per-cycle {start, data_in,
// expected x/valid/busy/done} records for single and interrupted frames,
// plus hand-written sequences for back-to-back frames, reset mid-frame and
// (with SEQ_TX_PARITY_EN) the parity bit.
// ---------------------------------------------------------------------------
module tb_seq_frame_tx;

   localparam int DATA_W = 8;
   localparam int SYNC_W = 4;
`ifdef SEQ_TX_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int FRAME_L = SYNC_W + DATA_W + PAR_W;

   // expected output codes, packed as {x, valid, busy, done}
   localparam logic [3:0] E_B0   = 4'b0110;
   localparam logic [3:0] E_B1   = 4'b1110;
   localparam logic [3:0] E_DONE = 4'b1001;
   localparam logic [3:0] E_IDLE = 4'b1000;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       start;
      logic [7:0] data;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   seq_frame_tx_if #(.DATA_W(DATA_W)) tx_if ();

   seq_frame_tx #(
      .DATA_W (DATA_W),
      .SYNC_W (SYNC_W),
      .SYNC   (4'b0110)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (tx_if)
   );

   function automatic void add(input logic st, input logic [7:0] d, input logic [3:0] e);
      vec_t v;
      v.start = st;
      v.data  = d;
      v.exp   = e;
      vecs.push_back(v);
   endfunction

   // Reference frame: sync pattern, payload MSB-first, optional even parity.
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      logic [FRAME_L-1:0] f;
`ifdef SEQ_TX_PARITY_EN
      f = {4'b0110, d, ^d};
`else
      f = {4'b0110, d};
`endif
      f = f << i;
      return f[FRAME_L-1];
   endfunction

   // Outputs are sampled 1 unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic st, input logic [7:0] d);
      tx_if.start   = st;
      tx_if.data_in = d;
   endtask

   task automatic check_output(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {tx_if.x, tx_if.valid, tx_if.busy, tx_if.done};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: x/valid/busy/done got %b expected %b", name, act, exp);
      end
   endtask

   // One full frame starting at the next edge, ending after the done check.
   // With hold=1 start stays high throughout so the next frame can follow.
   task automatic run_frame(input logic [7:0] d, input logic hold, input string name);
      apply_stimulus(1'b1, d);
      for (int i = 0; i < FRAME_L; i++) begin
         tick();
         if (i == 0 && !hold) apply_stimulus(1'b0, d);
         check_output($sformatf("%s bit%0d", name, i), {frame_bit(d, i), 3'b110});
      end
      tick();
      check_output($sformatf("%s done", name), E_DONE);
   endtask

   initial begin
      // Frame with 8'hA5: 0110 1010 0101, done, idle
      add(1'b1, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
`ifdef SEQ_TX_PARITY_EN
      add(1'b0, 8'hA5, E_B0);
`endif
      add(1'b0, 8'hA5, E_DONE);
      add(1'b0, 8'hA5, E_IDLE);
      // Second A5 frame; start pulsed with 8'h00 while bit 5 is on the line
      add(1'b1, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B1);
      add(1'b0, 8'hA5, E_B0);
      add(1'b0, 8'hA5, E_B1);
      add(1'b1, 8'h00, E_B0);
      add(1'b0, 8'h00, E_B1);
      add(1'b0, 8'h00, E_B0);
      add(1'b0, 8'h00, E_B0);
      add(1'b0, 8'h00, E_B1);
      add(1'b0, 8'h00, E_B0);
      add(1'b0, 8'h00, E_B1);
`ifdef SEQ_TX_PARITY_EN
      add(1'b0, 8'h00, E_B0);
`endif
      add(1'b0, 8'h00, E_DONE);
      add(1'b0, 8'h00, E_IDLE);

      // Power-on reset, then release.
      apply_stimulus(1'b0, 8'h00);
      reset = 1'b0;
      tick();
      tick();
      check_output("reset_state", E_IDLE);
      reset = 1'b1;
      tick();
      check_output("idle_after_release", E_IDLE);

      // Reset asserted mid-idle takes effect without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      check_output("async_reset_idle", E_IDLE);
      tick();
      reset = 1'b1;
      tick();
      check_output("idle_after_second_release", E_IDLE);

      // Table-driven single and interrupted frames.
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].start, vecs[i].data);
         tick();
         check_output($sformatf("vec%0d", i), vecs[i].exp);
      end

      // start held high: two frames separated only by the done cycle.
      run_frame(8'h3C, 1'b1, "b2b_first");
      run_frame(8'h3C, 1'b1, "b2b_second");
      apply_stimulus(1'b0, 8'h3C);
      tick();
      check_output("b2b_idle", E_IDLE);

      // Reset while bit 7 is on the line aborts the frame, no done pulse.
      apply_stimulus(1'b1, 8'hA5);
      tick();
      apply_stimulus(1'b0, 8'hA5);
      check_output("abort bit0", {frame_bit(8'hA5, 0), 3'b110});
      for (int i = 1; i < 7; i++) begin
         tick();
         check_output($sformatf("abort bit%0d", i), {frame_bit(8'hA5, i), 3'b110});
      end
      #2;
      reset = 1'b0;
      #1;
      check_output("abort_immediate", E_IDLE);
      tick();
      check_output("abort_hold", E_IDLE);
      reset = 1'b1;
      tick();
      check_output("abort_no_done", E_IDLE);
      tick();
      check_output("abort_stays_idle", E_IDLE);
      run_frame(8'hFF, 1'b0, "after_abort_ff");
      tick();
      check_output("after_abort_idle", E_IDLE);

`ifdef SEQ_TX_PARITY_EN
      // Parity frames: 8'h07 ends in 1, 8'h03 ends in 0.
      run_frame(8'h07, 1'b0, "par07");
      tick();
      run_frame(8'h03, 1'b0, "par03");
      tick();
      check_output("par_idle", E_IDLE);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
